router_nway: RTL

// - Parametrised successor of the 2-way stream router: demultiplexes one valid/ready stream onto
//   NUM_OUTPUTS valid/ready streams, selected by the top SEL_WIDTH bits of the input identity.
// - Each output has its own FIFO, so a stalled output does not block beats headed elsewhere

---
 rtl/router_nway_if.sv | 15 +
 rtl/router_nway.sv | 126 ++++++++++++
 2 files changed

// File: rtl/router_nway_if.sv
// Bundle of one or more valid/ready lanes, each carrying an identity tag and a payload.
// The router takes a single-lane bundle on its input and drives an N-lane bundle on its output.
interface router_nway_if #(
  parameter int LANES      = 1,
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 32
);
  logic [LANES-1:0]            valid;
  logic [LANES-1:0]            ready;
  logic [LANES*ID_WIDTH-1:0]   identity;
  logic [LANES*DATA_WIDTH-1:0] stream;

  modport master (output valid, output identity, output stream, input ready);
  modport slave  (input valid, input identity, input stream, output ready);
endinterface

// File: rtl/router_nway.sv
// Demultiplexes one valid/ready stream onto NUM_OUTPUTS streams, one FIFO per output,
// selected by the bits just above the forwarded identity; out-of-range selects are counted and dropped.
module router_nway #(
  parameter int identity_width = 2,
  parameter int stream_width   = 32,
  parameter int SEL_WIDTH      = 2,
  parameter int NUM_OUTPUTS    = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  router_nway_if.slave              axi_s,
  router_nway_if.master             axi_m,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = identity_width + stream_width;

  typedef enum logic [1:0] {INIT, RUN, FLUSH} state_t;
  state_t state, state_next;

  logic [ENTRY_W-1:0]     mem [NUM_OUTPUTS][FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr [NUM_OUTPUTS];
  logic [PTR_W-1:0]       rd_ptr [NUM_OUTPUTS];
  logic [CNT_W-1:0]       count [NUM_OUTPUTS];

  logic [SEL_WIDTH-1:0]   sel;
  logic                   sel_in_range;
  logic                   sel_full;
  logic                   accept;
  logic                   drop;
  logic [NUM_OUTPUTS-1:0] push;
  logic [NUM_OUTPUTS-1:0] pop;
  logic [NUM_OUTPUTS-1:0] not_empty;

  always_ff @(posedge clock) begin
    if (reset) state <= INIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    state_next = RUN;
      RUN:     if (flush) state_next = FLUSH;
      FLUSH:   if (!flush) state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  assign sel = axi_s.identity[identity_width +: SEL_WIDTH];

  // Ready looks only at the selected FIFO's count, never at the sink's ready.
  always_comb begin
    sel_in_range = 1'b0;
    sel_full     = 1'b0;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      if (sel == SEL_WIDTH'(k)) begin
        sel_in_range = 1'b1;
        sel_full     = (count[k] == CNT_W'(FIFO_DEPTH));
      end
    end
  end

  always_comb begin
    axi_s.ready = 1'b0;
    if (state == RUN) axi_s.ready = ~sel_full;
  end

  assign accept = axi_s.valid[0] & axi_s.ready[0] & ~flush;
  assign drop   = accept & ~sel_in_range;

  always_comb begin
    push      = '0;
    pop       = '0;
    not_empty = '0;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      not_empty[k] = (count[k] != '0);
      push[k]      = accept & (sel == SEL_WIDTH'(k));
      pop[k]       = not_empty[k] & axi_m.ready[k] & ~flush;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
        if (push[k] && !pop[k])      count[k] <= count[k] + CNT_W'(1);
        else if (!push[k] && pop[k]) count[k] <= count[k] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      if (push[k]) mem[k][wr_ptr[k]] <= {axi_s.identity[identity_width-1:0], axi_s.stream};
    end
  end

  always_comb begin
    axi_m.valid    = '0;
    axi_m.identity = '0;
    axi_m.stream   = '0;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      axi_m.valid[k] = not_empty[k];
      axi_m.identity[k*identity_width +: identity_width] = mem[k][rd_ptr[k]][stream_width +: identity_width];
      axi_m.stream[k*stream_width +: stream_width]       = mem[k][rd_ptr[k]][stream_width-1:0];
    end
  end

  // Saturates rather than wraps so a long-running fault stays visible.
  always_ff @(posedge clock) begin
    if (reset)                           drop_count <= '0;
    else if (drop && drop_count != '1)   drop_count <= drop_count + DROP_CNT_WIDTH'(1);
  end
endmodule
